id_ex_pipe_reg: RTL and testbench

Parametrised ID/EX pipeline boundary register with valid/ready handshake, two-entry skid buffer and synchronous flush. It sits between the decode stage (register-file read, sign extension, PC+4) and the execute stage. It replaces the plain always-load ID/EX latch, adding back-pressure from EX, bubble insertion on flush, and configurable operand count and widths.

---
 rtl/id_ex_pipe_reg_pkg.sv | 23 ++
 rtl/id_ex_pipe_reg_slot.sv | 35 +++
 rtl/id_ex_pipe_reg.sv | 102 ++++++++++
 tb/tb_id_ex_pipe_reg.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX boundary: control-bundle bit map and default widths.
// Latency: none (package only).
// Backpressure: not applicable.
package id_ex_pkg;

    // Bit positions inside the decoded control bundle.
    localparam int REG_WRITE  = 0;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 2;
    localparam int MEM_TO_REG = 3;
    localparam int ALU_SRC    = 4;
    localparam int REG_DST    = 5;
    localparam int BRANCH     = 6;
    localparam int ALU_OP_LO  = 7;
    localparam int ALU_OP_HI  = 9;

    // Bundle width follows the highest assigned control bit.
    localparam int CTRL_W_DEF     = ALU_OP_HI + 1;
    localparam int DATA_W_DEF     = 32;
    localparam int NUM_SRC_DEF    = 2;
    localparam int REG_ADDR_W_DEF = 5;

endpackage

// File: rtl/id_ex_pipe_reg_slot.sv
// One pipeline slot: payload register plus valid flag; clr beats load on the valid flag.
// Latency: one cycle from load to q/valid.
// Backpressure: none inside the slot; the parent decides when to load or clear.
//
// Ports: clk, reset (async, active-high), load, clr, d[W], q[W], valid.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else begin
            // Payload only moves on load, so a cleared slot keeps its old bits.
            if (load) begin
                q <= d;
            end
            if (clr) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX boundary register with valid/ready handshake, two-entry skid (M drives EX, S absorbs one stall beat).
// Latency: one cycle from accept to out_valid when M is empty; one beat per cycle with out_ready high.
// Backpressure: in_ready = ~S.valid straight from a flop, so it never depends combinationally on out_ready.
//
// Ports: clk, reset (async, active-high), flush (sync, drops held and incoming beats),
//        in_valid/in_ready + in_src/in_imm/in_pc/in_ctrl/in_rd from decode,
//        out_valid/out_ready + out_src/out_imm/out_pc/out_ctrl/out_rd to execute.
module id_ex_pipe_reg
    import id_ex_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int CTRL_W     = CTRL_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC*DATA_W-1:0] in_src,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [REG_ADDR_W-1:0]     in_rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_SRC*DATA_W-1:0] out_src,
    output logic [DATA_W-1:0]         out_imm,
    output logic [DATA_W-1:0]         out_pc,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [REG_ADDR_W-1:0]     out_rd
);

    localparam int SRC_W  = NUM_SRC * DATA_W;
    localparam int IMM_LO = SRC_W;
    localparam int PC_LO  = IMM_LO + DATA_W;
    localparam int CTL_LO = PC_LO + DATA_W;
    localparam int RD_LO  = CTL_LO + CTRL_W;
    localparam int SLOT_W = RD_LO + REG_ADDR_W;

    logic [SLOT_W-1:0] in_word;
    logic [SLOT_W-1:0] m_d;
    logic [SLOT_W-1:0] m_q;
    logic [SLOT_W-1:0] s_q;
    logic              m_vld;
    logic              s_vld;
    logic              accept;
    logic              take;
    logic              m_free;
    logic              m_load;
    logic              m_clr;
    logic              s_load;
    logic              s_clr;

    assign in_word = {in_rd, in_ctrl, in_pc, in_imm, in_src};

    assign in_ready  = ~s_vld;
    assign out_valid = m_vld;
    assign accept    = in_valid & in_ready;
    assign take      = m_vld & out_ready;

    // M can take a new beat this cycle if it is empty or its beat is leaving.
    assign m_free = ~m_vld | take;

    // S has priority into M to keep FIFO order; otherwise M refills from decode.
    assign m_d    = s_vld ? s_q : in_word;
    assign m_load = ~flush & m_free & (s_vld | accept);
    assign m_clr  = flush | (m_free & ~s_vld & ~accept);

    // S only catches a beat when M is stalled; in_ready guarantees S is empty then.
    assign s_load = ~flush & ~m_free & accept;
    assign s_clr  = flush | (m_free & s_vld);

    pipe_slot #(.W(SLOT_W)) u_slot_m (
        .clk   (clk),
        .reset (reset),
        .load  (m_load),
        .clr   (m_clr),
        .d     (m_d),
        .q     (m_q),
        .valid (m_vld)
    );

    pipe_slot #(.W(SLOT_W)) u_slot_s (
        .clk   (clk),
        .reset (reset),
        .load  (s_load),
        .clr   (s_clr),
        .d     (in_word),
        .q     (s_q),
        .valid (s_vld)
    );

    assign out_src  = m_q[SRC_W-1:0];
    assign out_imm  = m_q[IMM_LO +: DATA_W];
    assign out_pc   = m_q[PC_LO  +: DATA_W];
    // A bubble must never assert a control bit, even though stale payload is held.
    assign out_ctrl = m_vld ? m_q[CTL_LO +: CTRL_W] : '0;
    assign out_rd   = m_q[RD_LO  +: REG_ADDR_W];

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_src;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic [9:0]  in_ctrl;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_src;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [9:0]  out_ctrl;
    logic [4:0]  out_rd;

    // Narrow three-operand instance.
    logic        w_flush;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [47:0] w_in_src;
    logic [15:0] w_in_imm;
    logic [15:0] w_in_pc;
    logic [9:0]  w_in_ctrl;
    logic [4:0]  w_in_rd;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [47:0] w_out_src;
    logic [15:0] w_out_imm;
    logic [15:0] w_out_pc;
    logic [9:0]  w_out_ctrl;
    logic [4:0]  w_out_rd;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [9:0]  ctrl;
    } beat_t;

    beat_t model_q[$];

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_src    (in_src),
        .in_imm    (in_imm),
        .in_pc     (in_pc),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .out_imm   (out_imm),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd)
    );

    id_ex_pipe_reg #(.DATA_W(16), .NUM_SRC(3), .CTRL_W(10), .REG_ADDR_W(5)) dut_w (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_flush),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_src    (w_in_src),
        .in_imm    (w_in_imm),
        .in_pc     (w_in_pc),
        .in_ctrl   (w_in_ctrl),
        .in_rd     (w_in_rd),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_src   (w_out_src),
        .out_imm   (w_out_imm),
        .out_pc    (w_out_pc),
        .out_ctrl  (w_out_ctrl),
        .out_rd    (w_out_rd)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // All payload fields are derived from pc so a single number identifies a beat.
    function automatic logic [9:0] ctrl_of(input logic [31:0] pc);
        return pc[9:0] | 10'h001;
    endfunction

    task automatic beat(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_ctrl  = ctrl_of(pc);
        in_imm   = pc ^ 32'h0000_A5A5;
        in_src   = {pc, ~pc};
        in_rd    = pc[6:2];
    endtask

    initial begin
        logic [31:0] pcnt;
        logic        acc;
        logic        tk;
        beat_t       b;

        reset       = 1'b1;
        flush       = 1'b0;
        out_ready   = 1'b0;
        beat(1'b0, 32'h0);
        w_flush     = 1'b0;
        w_in_valid  = 1'b0;
        w_out_ready = 1'b0;
        w_in_src    = 48'h3333_2222_1111;
        w_in_imm    = 16'h00AA;
        w_in_pc     = 16'h0040;
        w_in_ctrl   = 10'h155;
        w_in_rd     = 5'd7;

        // Reset state.
        #12;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_pc", {32'd0, out_pc}, 64'd0);
        check("rst_out_ctrl", {54'd0, out_ctrl}, 64'd0);
        check("rst_out_src", out_src, 64'd0);
        check("rst_out_imm", {32'd0, out_imm}, 64'd0);
        check("rst_out_rd", {59'd0, out_rd}, 64'd0);
        reset = 1'b0;

        // Streaming at full rate.
        out_ready = 1'b1;
        beat(1'b1, 32'd4);
        tick;
        check("str_valid0", {63'd0, out_valid}, 64'd1);
        check("str_pc0", {32'd0, out_pc}, 64'd4);
        check("str_ctrl0", {54'd0, out_ctrl}, 64'h005);
        check("str_imm0", {32'd0, out_imm}, 64'h0000_A5A1);
        check("str_src0", out_src, 64'h0000_0004_FFFF_FFFB);
        check("str_rd0", {59'd0, out_rd}, 64'd1);
        beat(1'b1, 32'd8);
        tick;
        check("str_valid1", {63'd0, out_valid}, 64'd1);
        check("str_pc1", {32'd0, out_pc}, 64'd8);
        beat(1'b1, 32'd12);
        tick;
        check("str_valid2", {63'd0, out_valid}, 64'd1);
        check("str_pc2", {32'd0, out_pc}, 64'd12);
        beat(1'b0, 32'd0);
        tick;
        check("str_drain_valid", {63'd0, out_valid}, 64'd0);
        check("str_drain_ctrl", {54'd0, out_ctrl}, 64'd0);

        // Stall: 4 in M, 8 in S, 12 held at the source.
        out_ready = 1'b0;
        beat(1'b1, 32'd4);
        tick;
        check("stl_pc_m", {32'd0, out_pc}, 64'd4);
        check("stl_rdy_1", {63'd0, in_ready}, 64'd1);
        beat(1'b1, 32'd8);
        tick;
        check("stl_rdy_0", {63'd0, in_ready}, 64'd0);
        check("stl_pc_hold", {32'd0, out_pc}, 64'd4);
        beat(1'b1, 32'd12);
        tick;
        check("stl_pc_hold2", {32'd0, out_pc}, 64'd4);
        check("stl_rdy_hold", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        #1;
        check("stl_rdy_no_comb", {63'd0, in_ready}, 64'd0);
        tick;
        check("rec_pc8", {32'd0, out_pc}, 64'd8);
        check("rec_valid8", {63'd0, out_valid}, 64'd1);
        check("rec_rdy", {63'd0, in_ready}, 64'd1);
        tick;
        check("rec_pc12", {32'd0, out_pc}, 64'd12);
        check("rec_valid12", {63'd0, out_valid}, 64'd1);
        beat(1'b0, 32'd0);
        tick;
        check("rec_drain", {63'd0, out_valid}, 64'd0);

        // Flush with both slots full and a beat arriving.
        out_ready = 1'b0;
        beat(1'b1, 32'd20);
        tick;
        beat(1'b1, 32'd24);
        tick;
        check("fl_full", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        beat(1'b1, 32'd16);
        tick;
        flush = 1'b0;
        beat(1'b0, 32'd0);
        check("fl_valid", {63'd0, out_valid}, 64'd0);
        check("fl_ctrl", {54'd0, out_ctrl}, 64'd0);
        check("fl_rdy", {63'd0, in_ready}, 64'd1);
        check("fl_pc_held", {32'd0, out_pc}, 64'd20);
        out_ready = 1'b1;
        tick;
        tick;
        check("fl_no_ghost", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset between edges.
        out_ready = 1'b0;
        beat(1'b1, 32'd44);
        tick;
        beat(1'b0, 32'd0);
        check("ar_pre_valid", {63'd0, out_valid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", {63'd0, out_valid}, 64'd0);
        check("ar_pc", {32'd0, out_pc}, 64'd0);
        check("ar_ctrl", {54'd0, out_ctrl}, 64'd0);
        check("ar_rdy", {63'd0, in_ready}, 64'd1);
        #1;
        reset = 1'b0;
        tick;

        // Three 16-bit operands.
        w_in_valid  = 1'b1;
        w_out_ready = 1'b1;
        tick;
        w_in_valid = 1'b0;
        check("w_valid", {63'd0, w_out_valid}, 64'd1);
        check("w_src", {16'd0, w_out_src}, 64'h0000_3333_2222_1111);
        check("w_pc", {48'd0, w_out_pc}, 64'h40);
        check("w_ctrl", {54'd0, w_out_ctrl}, 64'h155);
        tick;
        check("w_drain", {63'd0, w_out_valid}, 64'd0);

        // Random traffic against a queue model.
        model_q.delete();
        pcnt = 32'h100;
        for (int i = 0; i < 10000; i++) begin
            beat(1'($urandom_range(0, 1)), pcnt);
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 19) == 0);
            pcnt      = pcnt + 32'd4;
            acc = in_valid && (model_q.size() < 2);
            tk  = (model_q.size() > 0) && out_ready;
            if (flush) begin
                model_q.delete();
            end else begin
                if (tk) begin
                    void'(model_q.pop_front());
                end
                if (acc) begin
                    b.pc   = in_pc;
                    b.ctrl = in_ctrl;
                    model_q.push_back(b);
                end
            end
            tick;
            check("rnd_valid", {63'd0, out_valid}, {63'd0, model_q.size() > 0});
            check("rnd_rdy", {63'd0, in_ready}, {63'd0, model_q.size() < 2});
            if (model_q.size() > 0) begin
                check("rnd_pc", {32'd0, out_pc}, {32'd0, model_q[0].pc});
                check("rnd_ctrl", {54'd0, out_ctrl}, {54'd0, model_q[0].ctrl});
            end else begin
                check("rnd_bubble_ctrl", {54'd0, out_ctrl}, 64'd0);
            end
        end
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
